// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg: opcodes, sequencer states, register codes and FunSel values shared by the register-file controller.
package rf_ctrl_pkg;
  typedef enum logic [2:0] {OP_NOP, OP_CLR, OP_LDI, OP_INC, OP_DEC, OP_MOV, OP_CNTDN, OP_RSV} op_e;
  typedef enum logic [2:0] {S_IDLE, S_SRC, S_LATCH, S_WRITE, S_SEL, S_EVAL, S_READ, S_DONE} state_e;
  localparam logic [2:0] REG_T1 = 3'd0, REG_T2 = 3'd1, REG_T3 = 3'd2, REG_T4 = 3'd3;
  localparam logic [2:0] REG_R1 = 3'd4, REG_R2 = 3'd5, REG_R3 = 3'd6, REG_R4 = 3'd7;
  localparam logic [1:0] FUN_CLR = 2'b00, FUN_LOAD = 2'b01, FUN_DEC = 2'b10, FUN_INC = 2'b11;
  function automatic logic [1:0] fun_of(op_e op);
    return op == OP_CLR ? FUN_CLR : op == OP_INC ? FUN_INC : (op == OP_DEC || op == OP_CNTDN) ? FUN_DEC : FUN_LOAD;
  endfunction
  function automatic state_e start_of(op_e op);
    return op inside {OP_CLR, OP_LDI, OP_INC, OP_DEC} ? S_WRITE : op == OP_MOV ? S_SRC : op == OP_CNTDN ? S_SEL : S_DONE;
  endfunction
endpackage

// File: rtl/rf_sel_decode.sv
// rf_sel_decode: turns a 3-bit register code into one-hot R/T enables (bit3 = R1/T1).
module rf_sel_decode (
  input  logic [2:0] code_i,
  input  logic       en_i,
  output logic [3:0] rsel_o,
  output logic [3:0] tsel_o
);
  logic [3:0] hot;
  assign hot = 4'b1000 >> code_i[1:0];
  assign rsel_o = (en_i && code_i[2]) ? hot : 4'b0000;
  assign tsel_o = (en_i && !code_i[2]) ? hot : 4'b0000;
endmodule

// File: rtl/rf_controller.sv
// rf_controller: sequences one micro-command into register-file write drive and reads the destination back.
module rf_controller
  import rf_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_op_i,
  input  logic [2:0]       cmd_dst_i,
  input  logic [2:0]       cmd_src_i,
  input  logic [WIDTH-1:0] cmd_imm_i,
  input  logic [WIDTH-1:0] rf_o1_i,
  output logic [WIDTH-1:0] rf_i_o,
  output logic [1:0]       rf_fun_sel_o,
  output logic [3:0]       rf_rsel_o,
  output logic [3:0]       rf_tsel_o,
  output logic [2:0]       rf_o1_sel_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);
  state_e state_q, state_d;
  op_e op_q, op_n;
  logic [2:0] dst_q, dst_n, src_q, src_n, o1_sel_q;
  logic [WIDTH-1:0] imm_q, imm_n, rf_i_q, result_q;
  logic [3:0] rsel_q, tsel_q, rsel_d, tsel_d;
  logic [1:0] fun_q;
  logic ready_q, done_q, accept;
  assign accept = cmd_valid_i && ready_q;
  // fields seen on the accept edge itself, so the first state can already use them
  assign op_n = accept ? op_e'(cmd_op_i) : op_q;
  assign dst_n = accept ? cmd_dst_i : dst_q;
  assign src_n = accept ? cmd_src_i : src_q;
  assign imm_n = accept ? cmd_imm_i : imm_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: state_d = accept ? start_of(op_n) : S_IDLE;
      S_SRC:          state_d = S_LATCH;
      S_LATCH:        state_d = S_WRITE;
      S_WRITE:        state_d = op_q == OP_CNTDN ? S_SEL : S_READ;
      S_SEL:          state_d = S_EVAL;
      S_EVAL:         state_d = rf_o1_i == '0 ? S_DONE : S_WRITE;
      S_READ:         state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end
  rf_sel_decode u_dec (
    .code_i(dst_n),
    .en_i  (state_d == S_WRITE),
    .rsel_o(rsel_d),
    .tsel_o(tsel_d)
  );
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      op_q     <= OP_NOP;
      dst_q    <= '0;
      src_q    <= '0;
      imm_q    <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      rsel_q   <= '0;
      tsel_q   <= '0;
      fun_q    <= FUN_CLR;
      rf_i_q   <= '0;
      o1_sel_q <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_n;
      dst_q   <= dst_n;
      src_q   <= src_n;
      imm_q   <= imm_n;
      ready_q <= state_d == S_IDLE || state_d == S_DONE;
      done_q  <= state_d == S_DONE;
      rsel_q  <= rsel_d;
      tsel_q  <= tsel_d;
      if (state_d == S_WRITE) fun_q <= fun_of(op_n);
      if (state_q == S_LATCH) rf_i_q <= rf_o1_i;
      else if (state_d == S_WRITE && op_n == OP_LDI) rf_i_q <= imm_n;
      if (state_d == S_SRC || state_d == S_LATCH) o1_sel_q <= src_n;
      else if (state_d inside {S_SEL, S_EVAL, S_READ}) o1_sel_q <= dst_n;
      if (state_d == S_DONE && (state_q == S_READ || state_q == S_EVAL)) result_q <= rf_o1_i;
    end
  end
  assign cmd_ready_o  = ready_q;
  assign done_o       = done_q;
  assign rf_rsel_o    = rsel_q;
  assign rf_tsel_o    = tsel_q;
  assign rf_fun_sel_o = fun_q;
  assign rf_i_o       = rf_i_q;
  assign rf_o1_sel_o  = o1_sel_q;
  assign result_o     = result_q;
endmodule

// File: tb/tb_rf_controller.sv
// tb_rf_controller: rf_controller driving a behavioural register file, checked against a command-level model.
module tb_rf_controller;
  import rf_ctrl_pkg::*;
  logic clk = 0, rst_n = 0, cmd_valid = 0;
  logic [2:0] cmd_op = 0, cmd_dst = 0, cmd_src = 0, o1sel;
  logic [7:0] cmd_imm = 0, rf_o1, rf_i, result;
  logic [1:0] fun;
  logic [3:0] rsel, tsel;
  logic cmd_ready, done;
  logic [7:0] rf [8] = '{default: 8'h00};
  logic [7:0] ref_rf [8] = '{default: 8'h00};
  int checks = 0, errors = 0, cyc = 0, done_at = -1, exp_wr = 0, wr_cnt = 0, m_t0 = 0, m_woff = 1;
  bit pending = 0, started = 0, chk_rfi = 0;
  logic [7:0] res_cur = 0, res_next = 0, exp_rfi = 0, m_old = 0;
  logic [2:0] m_op = 0, m_dst = 0;
  logic [1:0] exp_fun = 0;
  always #5 clk = ~clk;
  rf_controller #(.WIDTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_dst_i(cmd_dst), .cmd_src_i(cmd_src), .cmd_imm_i(cmd_imm),
    .rf_o1_i(rf_o1), .rf_i_o(rf_i), .rf_fun_sel_o(fun), .rf_rsel_o(rsel), .rf_tsel_o(tsel),
    .rf_o1_sel_o(o1sel), .done_o(done), .result_o(result)
  );
  // register file stand-in: combinational O1 read, enabled registers updated on the edge
  assign rf_o1 = rf[o1sel];
  function automatic logic [7:0] upd(logic [1:0] f, logic [7:0] v, logic [7:0] d);
    return f == 2'b00 ? 8'h00 : f == 2'b01 ? d : f == 2'b10 ? v - 8'd1 : v + 8'd1;
  endfunction
  always @(posedge clk)
    for (int k = 0; k < 4; k++) begin
      if (tsel[3-k]) rf[k] <= upd(fun, rf[k], rf_i);
      if (rsel[3-k]) rf[4+k] <= upd(fun, rf[4+k], rf_i);
    end
  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", nm, got, exp, cyc);
    end
  endtask
  // command-level model: final register values, latency and write count per accepted command
  always @(posedge clk) begin : model
    int t, lat, n;
    t = cyc;
    cyc++;
    if (!rst_n) begin
      if (started && pending) begin
        n = (t - m_t0) / 3;
        if (m_op == 3'd6) ref_rf[m_dst] = m_old - 8'(n < int'(m_old) ? n : int'(m_old));
        else if (t < m_t0 + m_woff) ref_rf[m_dst] = m_old;
      end
      started = 1;
      pending = 0;
      res_cur = 0;
    end else begin
      if (pending && done_at == t) pending = 0;
      if (cmd_valid && !pending) begin
        m_t0 = t; m_op = cmd_op; m_dst = cmd_dst; m_old = ref_rf[cmd_dst];
        exp_rfi = cmd_op == 3'd2 ? cmd_imm : ref_rf[cmd_src];
        chk_rfi = cmd_op == 3'd2 || cmd_op == 3'd5;
        lat = 3; exp_wr = 1;
        case (cmd_op)
          3'd1: begin ref_rf[cmd_dst] = 8'h00; exp_fun = 2'b00; end
          3'd2: begin ref_rf[cmd_dst] = cmd_imm; exp_fun = 2'b01; end
          3'd3: begin ref_rf[cmd_dst] = m_old + 8'd1; exp_fun = 2'b11; end
          3'd4: begin ref_rf[cmd_dst] = m_old - 8'd1; exp_fun = 2'b10; end
          3'd5: begin ref_rf[cmd_dst] = ref_rf[cmd_src]; exp_fun = 2'b01; lat = 5; end
          3'd6: begin ref_rf[cmd_dst] = 8'h00; exp_fun = 2'b10; lat = 3 * int'(m_old) + 3; exp_wr = int'(m_old); end
          default: begin lat = 1; exp_wr = 0; end
        endcase
        m_woff = cmd_op == 3'd5 ? 3 : 1;
        res_next = (cmd_op == 3'd0 || cmd_op == 3'd7) ? res_cur : ref_rf[cmd_dst];
        pending = 1;
        done_at = t + lat;
      end
      if (pending && done_at == cyc) res_cur = res_next;
    end
  end
  always @(negedge clk) begin : compare
    int code;
    bit exp_done;
    if (started) begin
      exp_done = pending && done_at == cyc;
      chk("done", int'(done), int'(exp_done));
      chk("ready", int'(cmd_ready), int'(!pending || exp_done));
      chk("result", int'(result), int'(res_cur));
      if ({rsel, tsel} != 8'h00) begin
        code = 0;
        for (int k = 0; k < 4; k++) begin
          if (tsel[3-k]) code = k;
          if (rsel[3-k]) code = 4 + k;
        end
        chk("wr_onehot", $countones({rsel, tsel}), 1);
        chk("wr_dst", code, int'(m_dst));
        chk("wr_fun", int'(fun), int'(exp_fun));
        if (chk_rfi) chk("wr_rfi", int'(rf_i), int'(exp_rfi));
        wr_cnt++;
      end
      if (exp_done) begin
        chk("wr_count", wr_cnt, exp_wr);
        wr_cnt = 0;
      end
      if (!rst_n) wr_cnt = 0;
    end
  end
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic issue(input logic [2:0] op, input logic [2:0] d, input logic [2:0] s, input logic [7:0] imm, input bit hold);
    int n = 0;
    cmd_valid = 1; cmd_op = op; cmd_dst = d; cmd_src = s; cmd_imm = imm;
    while (!cmd_ready && n < 2000) begin step(1); n++; end
    if (n == 2000) chk("issue_timeout", n, 0);
    step(1);
    if (!hold) cmd_valid = 0;
  endtask
  task automatic wait_done(output int lat, output int nw);
    lat = 1; nw = 0;
    while (!done && lat < 2000) begin
      if ({rsel, tsel} != 8'h00) nw++;
      step(1);
      lat++;
    end
  endtask
  initial begin : stim
    int lat, nw;
    step(2);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_en", int'({rsel, tsel}), 0);
    chk("rst_fun", int'(fun), 0);
    chk("rst_rfi", int'(rf_i), 0);
    chk("rst_o1sel", int'(o1sel), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    rst_n = 1;
    issue(3'd2, REG_R2, 3'd0, 8'h5A, 0);
    chk("ldi_rsel", int'(rsel), 4'b0100);
    chk("ldi_tsel", int'(tsel), 0);
    chk("ldi_fun", int'(fun), 1);
    chk("ldi_rfi", int'(rf_i), 8'h5A);
    step(2);
    chk("ldi_done", int'(done), 1);
    chk("ldi_result", int'(result), 8'h5A);
    issue(3'd2, REG_T4, 3'd0, 8'hFF, 1);
    cmd_op = 3'd3;
    step(2);
    chk("b2b_done1", int'(done & cmd_ready), 1);
    chk("b2b_result1", int'(result), 8'hFF);
    issue(3'd3, REG_T4, 3'd0, 8'h00, 0);
    step(2);
    chk("b2b_done2", int'(done), 1);
    chk("b2b_result2", int'(result), 8'h00);
    issue(3'd2, REG_R1, 3'd0, 8'h3C, 0);
    wait_done(lat, nw);
    issue(3'd5, REG_T1, REG_R1, 8'h00, 0);
    wait_done(lat, nw);
    chk("mov_lat", lat, 5);
    chk("mov_writes", nw, 1);
    chk("mov_result", int'(result), 8'h3C);
    issue(3'd2, REG_R3, 3'd0, 8'd4, 0);
    wait_done(lat, nw);
    issue(3'd6, REG_R3, 3'd0, 8'h00, 0);
    wait_done(lat, nw);
    chk("cntdn4_lat", lat, 15);
    chk("cntdn4_writes", nw, 4);
    chk("cntdn4_result", int'(result), 0);
    issue(3'd6, REG_R3, 3'd0, 8'h00, 0);
    wait_done(lat, nw);
    chk("cntdn0_lat", lat, 3);
    chk("cntdn0_writes", nw, 0);
    issue(3'd2, REG_R4, 3'd0, 8'h77, 0);
    wait_done(lat, nw);
    issue(3'd1, REG_R4, 3'd0, 8'h00, 0);
    wait_done(lat, nw);
    chk("clr_result", int'(result), 8'h00);
    issue(3'd4, REG_R4, 3'd0, 8'h00, 0);
    wait_done(lat, nw);
    chk("dec_wrap_result", int'(result), 8'hFF);
    issue(3'd2, REG_R3, 3'd0, 8'd9, 0);
    wait_done(lat, nw);
    issue(3'd6, REG_R3, 3'd0, 8'h00, 0);
    step(5);
    rst_n = 0;
    step(1);
    chk("rstmid_ready", int'(cmd_ready), 1);
    chk("rstmid_en", int'({rsel, tsel}), 0);
    chk("rstmid_done", int'(done), 0);
    chk("rstmid_r3", int'(rf[REG_R3]), 7);
    rst_n = 1;
    repeat (1500) begin
      cmd_valid = $urandom_range(0, 2) != 0;
      cmd_op = 3'($urandom);
      cmd_dst = 3'($urandom);
      cmd_src = 3'($urandom);
      cmd_imm = 8'($urandom);
      step(1);
    end
    cmd_valid = 0;
    step(800);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule

// File: doc/rf_controller.md
# rf_controller

Command-driven write-side sequencer for the 8-bit R1–R4 / T1–T4 register file. Accepts one micro-command at a time over a valid/ready handshake, translates it into FunSel/RSel/TSel/I/O1Sel drive, and reads the destination back through the O1 port. It reports completion with a one-cycle Done pulse and the post-operation value. It sits between the control unit and the register file; O2Sel is driven by the control unit, not by this block.

## Interface
- WIDTH, 8, data width of I/O1/CmdImm/Result.
- Clock  in  1  single clock, rising edge.
- Reset  in  1  synchronous, active-low.
- CmdValid  in  1  command present.
- CmdReady  out  1  block can accept a command.
- CmdOp  in  3  opcode: 000 NOP, 001 CLR, 010 LDI, 011 INC, 100 DEC, 101 MOV, 110 CNTDN, 111 reserved (treated as NOP).
- CmdDst  in  3  destination code: 000 T1, 001 T2, 010 T3, 011 T4, 100 R1, 101 R2, 110 R3, 111 R4.
- CmdSrc  in  3  MOV source code, same encoding as CmdDst.
- CmdImm  in  WIDTH  LDI immediate.
- RfO1  in  WIDTH  register file O1 read-back.
- RfI  out  WIDTH  register file data input.
- RfFunSel  out  2  00 clear, 01 load, 10 decrement, 11 increment.
- RfRSel  out  4  R enables; bit3 R1 … bit0 R4.
- RfTSel  out  4  T enables; bit3 T1 … bit0 T4.
- RfO1Sel  out  3  read select, same code as CmdDst.
- Done  out  1  one-cycle completion pulse.
- Result  out  WIDTH  destination value after the operation; valid with Done; held until the next Done.

## Operation
- Command is accepted on an edge with CmdValid && CmdReady. All fields are captured at that edge, and the inputs are don't-care afterwards. CmdValid is ignored while CmdReady=0.
- States: IDLE, SRC, LATCH, WRITE, SEL, EVAL, READ, DONE.
- CmdReady=1 in IDLE and DONE. A command accepted in DONE starts back-to-back, with no IDLE cycle.
- NOP/111: go to DONE. Result is unchanged.
- CLR/LDI/INC/DEC: WRITE, then READ, then DONE.
  - WRITE drives exactly one enable bit (the one-hot of CmdDst) with FunSel 00/01/11/10 respectively. For LDI, RfI=CmdImm.
  - READ has enables 0 and O1Sel=dst. RfO1 is captured into Result at the end of READ.
- MOV: SRC, LATCH, WRITE, READ, DONE.
  - SRC and LATCH drive O1Sel=src; RfO1 is captured into RfI at the end of LATCH.
  - WRITE uses FunSel=01. src==dst is executed normally and leaves the value unchanged.
- CNTDN: SEL, then EVAL.
  - Both states drive O1Sel=dst; RfO1 is sampled at the end of EVAL.
  - If the sample is 0, go to DONE with Result=0.
  - Otherwise go to WRITE with FunSel=10, then back to SEL.
- Enables are nonzero only in WRITE, and for exactly one cycle per write.
- Outside WRITE: RfRSel=RfTSel=0000; RfFunSel and RfI hold their last values.

## Timing
- All outputs are registered.
- Reset values: CmdReady=1 (IDLE), RfRSel=RfTSel=0000, RfFunSel=00, RfI=0, RfO1Sel=000, Done=0, Result=0.
- RfO1 must be valid one cycle after RfO1Sel changes.
- Latency from the accept edge (cycle 0) to the Done cycle:
  - NOP: 1.
  - CLR/LDI/INC/DEC: 3.
  - MOV: 5.
  - CNTDN with initial value N: 3N+3. N=0 gives 3 with no write issued; N=255 gives 768.
- Wrap-around: INC of 0xFF yields Result 0x00; DEC of 0x00 yields Result 0xFF. This is the register file's modular arithmetic; no saturation.
- Reset mid-operation: all states return to IDLE on that edge and enables drop to 0. Writes already issued stand, and no Done is produced.

## Structure
- Package rf_ctrl_pkg holds:
  - opcode enum;
  - state enum;
  - 3-bit register codes (T1..R4);
  - FunSel constants (CLR, LOAD, DEC, INC).
- Sub-module rf_sel_decode: 3-bit code plus enable in, RSel[3:0]/TSel[3:0] one-hot out (e.g. 010 -> TSel=0010, 101 -> RSel=0100).
- The bench pairs rf_controller with the existing register file block.

## Test plan
- Reset, then LDI dst=R2 imm=0x5A -> in cycle 1 RfRSel=0100, RfFunSel=01, RfI=0x5A; Done in cycle 3 with Result=0x5A.
- LDI T4=0xFF, then INC T4 back-to-back (CmdValid held through DONE) -> INC accepted in the DONE cycle of the LDI; second Done has Result=0x00.
- LDI R1=0x3C, then MOV src=R1 dst=T1 -> Done 5 cycles after accept with Result=0x3C; RfTSel=1000 for one cycle only.
- CNTDN on R3 preloaded to 4 -> exactly 4 single-cycle writes with FunSel=10; Done at cycle 15 with Result=0. CNTDN on 0 -> no write, Done at cycle 3.
- CLR R4 after LDI R4=0x77, then DEC R4 -> Results 0x00, then 0xFF.
- Assert Reset during the second iteration of CNTDN from 9 -> next cycle CmdReady=1 and enables 0; no Done; the register holds 8 or 7 depending on the reset cycle.
